hazard_stall_ctrl: RTL

//  Decode-side hazard controller of the 5-stage PCPU, directly upstream of the forwarding unit.

---
 rtl/hazard_stall_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Decode-side hazard controller for the 5-stage PCPU. It sits directly
// upstream of the forwarding unit and catches the cases that forwarding
// cannot cover:
//   * load-use hazards (a load in EX feeding the instruction in ID)
//   * branch-class instructions (branch / jal / jalr) that resolve in ID and
//     need an operand that EX, or a load in MEM, is still producing
// While a hazard is pending, PC and IF/ID are frozen and ID/EX gets a bubble.
// A taken ID-stage redirect flushes IF/ID, but only when no stall is active.
//
// A small FSM (IDLE / STALL) with a down-counter sustains stalls longer than
// one cycle. The stall length is decided once, in IDLE, and is not
// re-evaluated while the counter runs.
//
// Optional feature (macro HAZ_PERF_CNT_EN):
//   Adds the free-running performance counters stall_cycles and flush_count.
//   Both wrap modulo 2^CNT_W. Without the macro, the counters and their
//   ports are absent.
//
// Parameters
//   LD_BR_STALLS  stall cycles for a branch-class op waiting on a load in EX (1..3)
//   CNT_W         performance counter width (HAZ_PERF_CNT_EN only)
//   NPC_BRANCH / NPC_JUMP / NPC_JALR  NPCOp encodings of the branch-class ops
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   rs1, rs2, rs1_used, rs2_used  source registers of the ID instruction
//   NPCOp                         next-PC op of the ID instruction
//   br_taken                      ID-stage redirect taken
//   ID_EX_rd / _RegWrite / _MemRead  destination and controls of the EX instruction
//   EX_MEM_rd / _MemRead          destination and load flag of the MEM instruction
//   PC_write, IF_ID_write         0 = hold PC / hold IF/ID
//   IF_ID_flush                   1 = IF/ID loads a NOP
//   ID_EX_bubble                  1 = ID/EX loads a NOP
//   stall                         = ~PC_write
//   stall_cycles, flush_count     performance counters (HAZ_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int unsigned LD_BR_STALLS = 2,
    parameter int unsigned CNT_W        = 32,
    parameter logic [2:0]  NPC_BRANCH   = 3'b001,
    parameter logic [2:0]  NPC_JUMP     = 3'b010,
    parameter logic [2:0]  NPC_JALR     = 3'b100
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [2:0]       NPCOp,
    input  logic             br_taken,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             EX_MEM_MemRead,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             stall
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    // The counter must hold the largest stall length (LD_BR_STALLS).
    localparam int unsigned   CW      = $clog2(LD_BR_STALLS + 1);
    localparam logic [CW-1:0] LD_BR_N = CW'(LD_BR_STALLS);
    localparam logic [CW-1:0] ONE     = CW'(1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_STALL = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] needN;
    logic          isBranch;
    logic          matchEx;
    logic          matchMem;
    logic          stallRaw;
    logic          stallInt;

    // A source register matches a destination only when it is really read
    // and is not x0; comparing the source against x0 also rules out any
    // rd of x0.
    function automatic logic srcMatch(input logic [4:0] rd,
                                      input logic [4:0] r1, input logic u1,
                                      input logic [4:0] r2, input logic u2);
        logic m1;
        logic m2;
        m1 = u1 && (r1 != 5'd0) && (r1 == rd);
        m2 = u2 && (r2 != 5'd0) && (r2 == rd);
        return m1 || m2;
    endfunction

    // Required stall length for the instruction in ID, as a priority chain.
    // A branch-class op needs its operands in ID, so any pending producer in
    // EX stalls it, and a load in MEM stalls it for one more cycle. A normal
    // op only needs to wait out a load in EX; everything else is forwarded.
    always_comb begin
        isBranch = (NPCOp == NPC_BRANCH) || (NPCOp == NPC_JUMP) || (NPCOp == NPC_JALR);
        matchEx  = srcMatch(ID_EX_rd,  rs1, rs1_used, rs2, rs2_used);
        matchMem = srcMatch(EX_MEM_rd, rs1, rs1_used, rs2, rs2_used);
        needN    = '0;
        if (isBranch && ID_EX_MemRead && matchEx) begin
            needN = LD_BR_N;
        end else if (isBranch && ID_EX_RegWrite && matchEx) begin
            needN = ONE;
        end else if (isBranch && EX_MEM_MemRead && matchMem) begin
            needN = ONE;
        end else if (!isBranch && ID_EX_MemRead && matchEx) begin
            needN = ONE;
        end
    end

    // Next-state logic. The first stall cycle is produced combinationally
    // from IDLE; the counter then holds the cycles still to come, so the
    // total stall is exactly needN cycles. Leaving STALL when the count
    // reaches one lets ID re-evaluate in the very next cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stallRaw = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (needN != '0) begin
                    stallRaw = 1'b1;
                    if (needN > ONE) begin
                        cnt_d   = needN - ONE;
                        state_d = S_STALL;
                    end
                end
            end
            S_STALL: begin
                stallRaw = 1'b1;
                if (cnt_q <= ONE) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The outputs are gated by rstn so that a reset arriving in the middle
    // of a stall releases the pipeline immediately, not at the next edge.
    // A redirect seen during a stall is ignored, which keeps flush and
    // bubble mutually exclusive.
    always_comb begin
        stallInt     = rstn && stallRaw;
        stall        = stallInt;
        PC_write     = !stallInt;
        IF_ID_write  = !stallInt;
        ID_EX_bubble = stallInt;
        IF_ID_flush  = rstn && br_taken && !stallInt;
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stallCycles_q;
    logic [CNT_W-1:0] flushCount_q;

    // Performance counters; they wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stallCycles_q <= '0;
            flushCount_q  <= '0;
        end else begin
            if (stallInt) begin
                stallCycles_q <= stallCycles_q + 1'b1;
            end
            if (IF_ID_flush) begin
                flushCount_q <= flushCount_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stallCycles_q;
    assign flush_count  = flushCount_q;
`endif

endmodule
